// File: rtl/snn_aer_encoder.sv
// Serialises per-tick spike vectors into {neuron_addr, ts} address events,
// buffered in a first-word-fall-through FIFO behind a valid/ready stream.
module snn_aer_encoder #(
  parameter int NUM_NEURONS = 2,
  parameter int ADDR_W      = ($clog2(NUM_NEURONS) > 0) ? $clog2(NUM_NEURONS) : 1,
  parameter int TS_W        = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int OVF_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_en,
  input  logic [NUM_NEURONS-1:0]        post_spikes,
  output logic                          aer_valid,
  input  logic                          aer_ready,
  output logic [ADDR_W-1:0]             aer_addr,
  output logic [TS_W-1:0]               aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [OVF_W-1:0]              ovf_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int PC_W  = $clog2(NUM_NEURONS) + 1;
  localparam int SUM_W = ((OVF_W > PC_W) ? OVF_W : PC_W) + 1;
  localparam int WORD_W = ADDR_W + TS_W;
  localparam logic [SUM_W-1:0] OVF_MAX = (SUM_W'(1) << OVF_W) - SUM_W'(1);

  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NUM_NEURONS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = ADDR_W'(i);
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_NEURONS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      popcount = popcount + PC_W'(v[i]);
  endfunction

  function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] a,
                                               input logic [PC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    sat_add = (s > OVF_MAX) ? '1 : OVF_W'(s);
  endfunction

  logic [TS_W-1:0]        ts_cnt_q, ts_cnt_d;
  logic [NUM_NEURONS-1:0] snapshot_q, snapshot_d;
  logic [TS_W-1:0]        snap_ts_q, snap_ts_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OVF_W-1:0]       ovf_cnt_q, ovf_cnt_d;
  logic [WORD_W-1:0]      mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  level;
  logic              full, pop, push;
  logic [ADDR_W-1:0] scan_idx;
  logic [WORD_W-1:0] head;

  always_comb begin
    level      = wr_ptr_q - rd_ptr_q;
    full       = (level == PTR_W'(FIFO_DEPTH));
    pop        = (level != '0) & aer_ready;
    scan_idx   = lowest_idx(snapshot_q);
    // A new tick takes priority over scanning: no partial push in the load cycle.
    push       = (snapshot_q != '0) & ~tick_en & (~full | pop);
    ts_cnt_d   = ts_cnt_q;
    snapshot_d = snapshot_q;
    snap_ts_d  = snap_ts_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (tick_en) begin
      snapshot_d = post_spikes;
      snap_ts_d  = ts_cnt_q;
      ts_cnt_d   = ts_cnt_q + TS_W'(1);
      if (snapshot_q != '0) ovf_cnt_d = sat_add(ovf_cnt_q, popcount(snapshot_q));
    end else if (push) begin
      snapshot_d = snapshot_q & (snapshot_q - NUM_NEURONS'(1));
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      snapshot_q <= '0;
      snap_ts_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      snapshot_q <= snapshot_d;
      snap_ts_q  <= snap_ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Storage is not reset; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[IDX_W-1:0]] <= {scan_idx, snap_ts_q};
  end

  assign head       = mem[rd_ptr_q[IDX_W-1:0]];
  assign aer_valid  = (level != '0);
  assign aer_addr   = aer_valid ? head[TS_W +: ADDR_W] : '0;
  assign aer_ts     = aer_valid ? head[TS_W-1:0] : '0;
  assign fifo_level = level;
  assign busy       = (snapshot_q != '0);
  assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_snn_aer_encoder.sv
// Randomised scoreboard bench for snn_aer_encoder against a queue-based model.
module tb_snn_aer_encoder;
  localparam int NN = 8, AW = 3, TSW = 4, DEPTH = 8, OW = 4;
  localparam int OVF_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_en = 1'b0;
  logic [NN-1:0] post_spikes = '0;
  logic          aer_ready = 1'b0;
  logic          aer_valid, busy;
  logic [AW-1:0] aer_addr;
  logic [TSW-1:0] aer_ts;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [OW-1:0] ovf_cnt;

  snn_aer_encoder #(.NUM_NEURONS(NN), .ADDR_W(AW), .TS_W(TSW),
                    .FIFO_DEPTH(DEPTH), .OVF_W(OW)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .post_spikes(post_spikes),
    .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_addr(aer_addr),
    .aer_ts(aer_ts), .fifo_level(fifo_level), .busy(busy), .ovf_cnt(ovf_cnt));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit started = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending spikes as an ordered list of indices, FIFO as queues.
  int pend_q[$];
  int exp_addr_q[$], exp_ts_q[$];
  int m_ts = 0, m_snap_ts = 0, m_level = 0, m_ovf = 0;

  always @(posedge clk) begin : model
    bit m_pop;
    if (rst) begin
      pend_q.delete(); exp_addr_q.delete(); exp_ts_q.delete();
      m_ts = 0; m_snap_ts = 0; m_level = 0; m_ovf = 0;
    end else begin
      m_pop = (m_level > 0) && aer_ready;
      if (tick_en) begin
        m_ovf = m_ovf + pend_q.size();
        if (m_ovf > OVF_MAX) m_ovf = OVF_MAX;
        pend_q.delete();
        for (int i = 0; i < NN; i++) if (post_spikes[i]) pend_q.push_back(i);
        m_snap_ts = m_ts;
        m_ts = (m_ts + 1) % (1 << TSW);
      end else if (pend_q.size() > 0 && (m_level < DEPTH || m_pop)) begin
        exp_addr_q.push_back(pend_q.pop_front());
        exp_ts_q.push_back(m_snap_ts);
        m_level++;
      end
      if (m_pop) m_level--;
    end
  end

  bit hold_v = 0;
  int hold_a = 0, hold_t = 0;

  always @(negedge clk) begin : monitor
    if (started) begin
      chk("fifo_level", int'(fifo_level), m_level);
      chk("aer_valid", int'(aer_valid), int'(m_level != 0));
      chk("busy", int'(busy), int'(pend_q.size() != 0));
      chk("ovf_cnt", int'(ovf_cnt), m_ovf);
      if (hold_v && aer_valid) begin
        chk("hold_addr", int'(aer_addr), hold_a);
        chk("hold_ts", int'(aer_ts), hold_t);
      end
      if (aer_valid && aer_ready) begin
        chk("sb_pending", int'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) begin
          chk("evt_addr", int'(aer_addr), exp_addr_q.pop_front());
          chk("evt_ts", int'(aer_ts), exp_ts_q.pop_front());
        end
      end
      hold_v = aer_valid && !aer_ready;
      hold_a = int'(aer_addr);
      hold_t = int'(aer_ts);
    end
  end

  task automatic cyc(input logic t, input logic [NN-1:0] s, input logic r);
    @(posedge clk); #1;
    tick_en = t; post_spikes = s; aer_ready = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, r);
  endtask

  initial begin
    @(posedge clk); #1;
    started = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", int'(aer_addr), 0);
    chk("rst_ts", int'(aer_ts), 0);

    cyc(1'b1, 8'hA4, 1'b1); idle(6, 1'b1);
    cyc(1'b1, 8'h03, 1'b1); idle(5, 1'b1);

    // Fill the FIFO, stall a second tick, then overwrite it to force drops.
    cyc(1'b1, 8'hFF, 1'b0); idle(10, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0); idle(4, 1'b0);
    cyc(1'b1, 8'h07, 1'b0); idle(3, 1'b0);
    idle(25, 1'b1);

    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, 8'h01, 1'b1); idle(2, 1'b1);
    end
    cyc(1'b1, 8'h00, 1'b1); idle(2, 1'b1);

    for (int c = 0; c < 1500; c++) begin
      logic r;
      if ((c / 100) % 2 == 0) r = ($urandom_range(0, 9) < 8);
      else r = ($urandom_range(0, 9) < 2);
      cyc(($urandom_range(0, 5) == 0), NN'($urandom), r);
    end

    // Reset in the middle of a stalled drain.
    cyc(1'b1, 8'hFF, 1'b0); idle(5, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_level", int'(fifo_level), 0);
    chk("rst_mid_ovf", int'(ovf_cnt), 0);
    chk("rst_mid_valid", int'(aer_valid), 0);

    cyc(1'b1, 8'h81, 1'b1); idle(30, 1'b1);
    @(negedge clk);
    chk("drained", exp_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
